vga_timing_gen: RTL and testbench

- Generates the VGA raster timing that every graphics-path consumer uses: active-low hsync/vsync, a visible flag, the current pixel coordinates and a pixel-clock enable.
- Sits between the system clock and the pixel-fetch/address logic and the DAC.
- Sync outputs feed asynchronous resets downstream, so every output comes straight from a flop and is glitch-free.

---
 rtl/vga_timing_if.sv | 19 +
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to its consumers
// (pixel fetch, address logic, DAC sync drivers).
interface vga_timing_if;
   logic        pix_en;
   logic        hsync;
   logic        vsync;
   logic        visible;
   logic [10:0] h_pos;
   logic [9:0]  v_pos;
   logic        frame_start;

   modport master (
      output pix_en, hsync, vsync, visible, h_pos, v_pos, frame_start
   );

   modport slave (
      input pix_en, hsync, vsync, visible, h_pos, v_pos, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and
// registered sync/visible decode. Every output is driven directly by a flop.
module vga_timing_gen #(
   parameter int CLK_DIV = 2,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   vga_timing_if.master  vga
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [10:0]   H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0]   H_VIS_W    = 11'(H_VIS);
   localparam logic [10:0]   H_SYNC_BEG = 11'(H_VIS + H_FP);
   localparam logic [10:0]   H_SYNC_END = 11'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]    V_VIS_W    = 10'(V_VIS);
   localparam logic [9:0]    V_SYNC_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0]    V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

   logic [DW-1:0] div_cnt, div_nxt;
   logic [10:0]   h_q, h_nxt;
   logic [9:0]    v_q, v_nxt;
   logic          tick, h_wrap, v_wrap;
   logic          pix_en_q, hsync_q, vsync_q, visible_q, frame_start_q;

   always_comb begin
      tick    = enable && (div_cnt == DIV_LAST);
      h_wrap  = (h_q == H_LAST);
      v_wrap  = (v_q == V_LAST);
      div_nxt = div_cnt;
      h_nxt   = h_q;
      v_nxt   = v_q;
      if (enable) begin
         div_nxt = tick ? '0 : div_cnt + 1'b1;
      end
      if (tick) begin
         if (h_wrap) begin
            h_nxt = '0;
            v_nxt = v_wrap ? '0 : v_q + 1'b1;
         end else begin
            h_nxt = h_q + 1'b1;
         end
      end
   end

   // Decode from the next-state counters so sync/visible line up with the
   // h_pos/v_pos presented in the same cycle; gating on enable makes them hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt       <= '0;
         h_q           <= '0;
         v_q           <= '0;
         pix_en_q      <= 1'b0;
         frame_start_q <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         visible_q     <= 1'b0;
      end else begin
         div_cnt       <= div_nxt;
         h_q           <= h_nxt;
         v_q           <= v_nxt;
         pix_en_q      <= tick;
         frame_start_q <= tick && h_wrap && v_wrap;
         if (enable) begin
            visible_q <= (h_nxt < H_VIS_W) && (v_nxt < V_VIS_W);
            hsync_q   <= !((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END));
            vsync_q   <= !((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END));
         end
      end
   end

   assign vga.pix_en      = pix_en_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.visible     = visible_q;
   assign vga.h_pos       = h_q;
   assign vga.v_pos       = v_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (15x8) so full frames stay short;
// a pixel-count model feeds a scoreboard queue compared after every clk edge.
module tb_vga_timing_gen;

  localparam int CD = 2;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;

  typedef struct packed {
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        visible;
    logic [10:0] h;
    logic [9:0]  v;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  vga_timing_if vif ();
  vga_timing_if vif1 ();

  vga_timing_gen #(.CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    dut (.clk(clk), .reset(reset), .enable(enable), .vga(vif));

  vga_timing_gen #(.CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                   .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
    dut1 (.clk(clk), .reset(reset), .enable(enable), .vga(vif1));

  always #5 clk = ~clk;

  int   pass_cnt = 0, total_cnt = 0;
  obs_t exp_q[$];

  int   m_div, m_p;
  logic m_pix, m_fs, m_dec;
  int   cyc, sync_cnt, vs_cnt, vis_cnt, fs_cnt, fs_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic int m_h();
    return m_p % HT;
  endfunction

  function automatic int m_v();
    return (m_p / HT) % VT;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int h, v;
    h = m_h();
    v = m_v();
    o.pix_en  = m_pix;
    o.fs      = m_fs;
    o.h       = 11'(h);
    o.v       = 10'(v);
    o.visible = m_dec && (h < HV) && (v < VV);
    o.hsync   = !((h >= HV + HF) && (h < HV + HF + HS));
    o.vsync   = !((v >= VV + VF) && (v < VV + VF + VS));
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pix_en  = vif.pix_en;
    o.hsync   = vif.hsync;
    o.vsync   = vif.vsync;
    o.visible = vif.visible;
    o.h       = vif.h_pos;
    o.v       = vif.v_pos;
    o.fs      = vif.frame_start;
    return o;
  endfunction

  task automatic model_reset();
    m_div = 0; m_p = 0; m_pix = 1'b0; m_fs = 1'b0; m_dec = 1'b0;
    cyc = 0; sync_cnt = 0; vs_cnt = 0; vis_cnt = 0; fs_cnt = 0; fs_cyc = -1;
  endtask

  task automatic step();
    obs_t e;
    m_pix = 1'b0;
    m_fs  = 1'b0;
    if (enable) begin
      m_dec = 1'b1;
      if (m_div == CD - 1) begin
        m_div = 0;
        m_pix = 1'b1;
        m_p++;
        m_fs = (m_p % FR) == 0;
      end else begin
        m_div++;
      end
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("raster", 32'(dut_obs()), 32'(e));
    if (vif.pix_en && !vif.hsync)  sync_cnt++;
    if (vif.pix_en && !vif.vsync)  vs_cnt++;
    if (vif.pix_en && vif.visible) vis_cnt++;
    if (vif.frame_start) begin
      fs_cnt++;
      fs_cyc = cyc;
    end
  endtask

  task automatic wait_model(input string tag, input int th, input int tv, input int maxc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_pix && m_h() == th && (tv < 0 || m_v() == tv)) && n < maxc);
    check(tag, 32'(m_pix && m_h() == th && (tv < 0 || m_v() == tv)), 32'd1);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_state", 32'(dut_obs()), 32'(model_out()));
    check("reset_hsync", 32'(vif.hsync), 32'd1);

    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    step();
    check("edge1_pix_en", 32'(vif.pix_en), 32'd0);
    step();
    check("edge2_pix_en", 32'(vif.pix_en), 32'd1);
    check("edge2_h_pos", 32'(vif.h_pos), 32'd1);

    wait_model("wait_line_wrap", 0, 1, 4 * HT * CD);
    check("line_hsync_pix", 32'(sync_cnt), 32'(HS));
    check("line_visible_pix", 32'(vis_cnt), 32'(HV));
    check("line_wrap_h", 32'(vif.h_pos), 32'd0);
    check("line_wrap_v", 32'(vif.v_pos), 32'd1);

    wait_model("wait_vis_last", HV - 1, VV - 1, 4 * FR);
    check("vis_at_last", 32'(vif.visible), 32'd1);
    wait_model("wait_vis_hend", HV, VV - 1, 4 * HT);
    check("vis_past_h", 32'(vif.visible), 32'd0);
    wait_model("wait_vis_vend", 0, VV, 4 * HT * CD);
    check("vis_past_v", 32'(vif.visible), 32'd0);
    wait_model("wait_frame", 0, 0, 4 * FR * CD);
    check("vis_new_frame", 32'(vif.visible), 32'd1);
    check("frame_start_pulse", 32'(vif.frame_start), 32'd1);
    check("frame_start_count", 32'(fs_cnt), 32'd1);
    check("frame_start_cycle", 32'(fs_cyc), 32'(FR * CD));
    check("vsync_low_pix", 32'(vs_cnt), 32'(VS * HT));
    step();
    check("frame_start_once", 32'(vif.frame_start), 32'd0);

    wait_model("wait_pause_pt", 5, -1, 4 * HT * CD);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("pause_pix_en", 32'(vif.pix_en), 32'd0);
      check("pause_h_pos", 32'(vif.h_pos), 32'd5);
    end
    enable = 1'b1;
    wait_model("wait_resume", 6, -1, 2 * CD);
    check("resume_h_pos", 32'(vif.h_pos), 32'd6);

    wait_model("wait_hsync_mid", HV + HF + 1, 3, 4 * FR * CD);
    check("pre_reset_hsync", 32'(vif.hsync), 32'd0);
    reset = 1'b0;
    #1;
    model_reset();
    check("async_reset", 32'(dut_obs()), 32'(model_out()));
    repeat (3) @(posedge clk);
    #1;
    check("held_reset", 32'(dut_obs()), 32'(model_out()));

    @(negedge clk);
    reset = 1'b1;
    step();
    check("restart_edge1_pix", 32'(vif.pix_en), 32'd0);
    check("div1_pix_en_e1", 32'(vif1.pix_en), 32'd1);
    check("div1_h_pos_e1", 32'(vif1.h_pos), 32'd1);
    step();
    check("restart_edge2_pix", 32'(vif.pix_en), 32'd1);
    check("restart_edge2_h", 32'(vif.h_pos), 32'd1);
    for (int k = 3; k <= 6; k++) begin
      step();
      check("div1_pix_en", 32'(vif1.pix_en), 32'd1);
      check("div1_h_pos", 32'(vif1.h_pos), 32'(k));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
